// File: rtl/shift_tx_pkg.sv
// shift_tx_pkg: shared types and helpers for the serial-transmit controller.
//   state_e : controller FSM states (IDLE, SHIFT, DONE)
//   cnt_w   : counter width for a count range of v, $clog2-based, never below 1
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_w(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/shift_reg_en.sv
// shift_reg_en: N-bit right-shift register with parallel load.
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   load       : capture p_in (wins over shift_en)
//   shift_en   : shift right one place, s_in entering the MSB
//   s_in       : serial input bit
//   p_in       : parallel load value
//   p_out      : register contents
//   s_out      : LSB of the register
module shift_reg_en #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic         s_in,
  input  logic [N-1:0] p_in,
  output logic [N-1:0] p_out,
  output logic         s_out
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)          q_d = p_in;
    else if (shift_en) q_d = {s_in, q_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign p_out = q_q;
  assign s_out = q_q[0];

endmodule

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: serializes N-bit words LSB-first, each bit held DIV clocks.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : producer offers in_data
//   in_data    : parallel word (captured on in_valid & in_ready)
//   in_ready   : high only in IDLE
//   s_out      : serial data, 0 when not shifting
//   s_valid    : s_out carries a data bit
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse after the last bit's full period
// Outputs are pure decodes of state and the register LSB, so nothing on the
// input side reaches an output combinationally.
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         s_out,
  output logic         s_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = cnt_w(N);
  localparam int DW = cnt_w(DIV);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            load, shift_en, sr_lsb;
  logic [N-1:0]    sr_par;
  logic            unused_par;

  shift_reg_en #(.N(N)) u_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .s_in     (1'b0),
    .p_in     (in_data),
    .p_out    (sr_par),
    .s_out    (sr_lsb)
  );

  // Parallel view of the register is not needed here.
  assign unused_par = ^sr_par;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DW'(DIV - 1)) begin
          div_cnt_d = '0;
          // Last bit: leave the register alone, it is cleared on next load.
          if (bit_cnt_q == BW'(N - 1)) begin
            state_d = DONE;
          end else begin
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign s_valid  = (state_q == SHIFT);
  assign busy     = (state_q == SHIFT) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign s_out    = s_valid & sr_lsb;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: instance A (N=8, DIV=4), instance B (N=4, DIV=1).
// A word-level reference model tracks edges since the accepted handshake and
// derives every output from that age and the captured word.
module tb_shift_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: N=8, DIV=4 ----------------
  logic       a_reset = 1'b1, a_valid = 1'b0;
  logic [7:0] a_data  = '0;
  logic       a_in_ready, a_s_out, a_s_valid, a_busy, a_done;

  shift_tx_ctrl #(.N(8), .DIV(4)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_in_ready), .s_out(a_s_out), .s_valid(a_s_valid),
    .busy(a_busy), .done(a_done)
  );

  // ---------------- instance B: N=4, DIV=1 ----------------
  logic       b_reset = 1'b1, b_valid = 1'b0;
  logic [3:0] b_data  = '0;
  logic       b_in_ready, b_s_out, b_s_valid, b_busy, b_done;

  shift_tx_ctrl #(.N(4), .DIV(1)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_in_ready), .s_out(b_s_out), .s_valid(b_s_valid),
    .busy(b_busy), .done(b_done)
  );

  wire [4:0] obs_a = {a_in_ready, a_s_out, a_s_valid, a_busy, a_done};
  wire [4:0] obs_b = {b_in_ready, b_s_out, b_s_valid, b_busy, b_done};

  // ---------------- reference model ----------------
  // Expected {in_ready, s_out, s_valid, busy, done} for a word accepted
  // 'age' edges ago: bit age/div during the first n*div cycles, then done.
  function automatic logic [4:0] exp_vec(input bit act, input int age,
                                         input logic [7:0] w, input int n,
                                         input int div);
    if (!act)            return 5'b10000;
    else if (age < n*div) return {1'b0, w[age/div], 3'b110};
    else                 return 5'b00011;
  endfunction

  bit         ma_act = 0, mb_act = 0;
  int         ma_age = 0, mb_age = 0;
  logic [7:0] ma_word = '0, mb_word = '0;
  int         hs_a[$];
  int         hs_b[$];

  always @(posedge clk) begin
    if (a_reset) begin
      ma_act <= 0; ma_age <= 0;
    end else if (ma_act) begin
      if (ma_age == 8*4) ma_act <= 0;
      ma_age <= ma_age + 1;
    end else if (a_valid) begin
      ma_act <= 1; ma_age <= 0; ma_word <= a_data; hs_a.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (b_reset) begin
      mb_act <= 0; mb_age <= 0;
    end else if (mb_act) begin
      if (mb_age == 4*1) mb_act <= 0;
      mb_age <= mb_age + 1;
    end else if (b_valid) begin
      mb_act <= 1; mb_age <= 0; mb_word <= {4'b0, b_data}; hs_b.push_back(cyc);
    end
  end

  logic [4:0] exp_a, exp_b;
  always_comb exp_a = exp_vec(ma_act, ma_age, ma_word, 8, 4);
  always_comb exp_b = exp_vec(mb_act, mb_age, mb_word, 4, 1);

  // ---------------- scenarios ----------------
  task test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== 5'b10000) begin
        fails++; $display("FAIL reset_a k=%0d: got %b want 10000", k, obs_a);
      end
      tests++;
      if (obs_b !== 5'b10000) begin
        fails++; $display("FAIL reset_b k=%0d: got %b want 10000", k, obs_b);
      end
    end
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
  endtask

  task test_single();
    logic sq[$];
    int dn;
    logic [7:0] got;
    dn = 0; got = '0;
    a_valid = 1'b1; a_data = 8'hA5;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 0) a_valid = 1'b0;
      tests++;
      if (obs_a !== exp_a) begin
        fails++; $display("FAIL single k=%0d: got %b want %b", k, obs_a, exp_a);
      end
      if (k == 32) begin
        tests++;
        if (a_done !== 1'b1) begin
          fails++; $display("FAIL single_done_cycle: got %b want 1", a_done);
        end
      end
      if (k == 33) begin
        tests++;
        if (a_in_ready !== 1'b1) begin
          fails++; $display("FAIL single_ready_back: got %b want 1", a_in_ready);
        end
      end
      if (a_s_valid) sq.push_back(a_s_out);
      if (a_done) dn++;
    end
    if (sq.size() == 32) for (int j = 0; j < 8; j++) got[j] = sq[j*4];
    tests++;
    if (sq.size() != 32 || got !== 8'hA5) begin
      fails++; $display("FAIL single_bits: got %h (%0d samples) want a5 (32)", got, sq.size());
    end
    tests++;
    if (dn != 1) begin
      fails++; $display("FAIL single_done_count: got %0d want 1", dn);
    end
  endtask

  task test_ignored();
    logic sq[$];
    logic [7:0] got;
    int n0;
    got = '0;
    n0 = hs_a.size();
    a_valid = 1'b1; a_data = 8'hA5;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 0)  a_data  = 8'h3C;
      if (k == 34) a_valid = 1'b0;
      tests++;
      if (obs_a !== exp_a) begin
        fails++; $display("FAIL ignored k=%0d: got %b want %b", k, obs_a, exp_a);
      end
      if (k < 33 && a_s_valid) sq.push_back(a_s_out);
      if (k == 34) begin
        tests++;
        if ({a_s_valid, a_s_out} !== 2'b10) begin
          fails++; $display("FAIL ignored_3c_first_bit: got %b want 10", {a_s_valid, a_s_out});
        end
      end
    end
    if (sq.size() == 32) for (int j = 0; j < 8; j++) got[j] = sq[j*4];
    tests++;
    if (got !== 8'hA5) begin
      fails++; $display("FAIL ignored_bits: got %h want a5", got);
    end
    tests++;
    if (hs_a.size() != n0 + 2 || hs_a[hs_a.size()-1] - hs_a[hs_a.size()-2] != 34) begin
      fails++; $display("FAIL ignored_hs_gap: got %0d handshakes want 2 spaced 34", hs_a.size() - n0);
    end
  endtask

  task test_reset_mid();
    logic sq[$];
    int dn;
    logic [7:0] got;
    dn = 0; got = '0;
    a_valid = 1'b1; a_data = 8'hA5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0)  a_valid = 1'b0;
      if (k == 13) a_reset = 1'b1;
      if (k == 14) begin
        a_reset = 1'b0;
        tests++;
        if (obs_a !== 5'b10000) begin
          fails++; $display("FAIL midreset_idle: got %b want 10000", obs_a);
        end
      end
      tests++;
      if (obs_a !== exp_a) begin
        fails++; $display("FAIL midreset k=%0d: got %b want %b", k, obs_a, exp_a);
      end
      if (a_done) dn++;
    end
    tests++;
    if (dn != 0) begin
      fails++; $display("FAIL midreset_no_done: got %0d want 0", dn);
    end
    a_valid = 1'b1; a_data = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 0) a_valid = 1'b0;
      tests++;
      if (obs_a !== exp_a) begin
        fails++; $display("FAIL after_reset k=%0d: got %b want %b", k, obs_a, exp_a);
      end
      if (a_s_valid) sq.push_back(a_s_out);
      if (a_done) dn++;
    end
    if (sq.size() == 32) for (int j = 0; j < 8; j++) got[j] = sq[j*4];
    tests++;
    if (got !== 8'hFF || dn != 1) begin
      fails++; $display("FAIL after_reset_word: got %h done=%0d want ff done=1", got, dn);
    end
  endtask

  task test_div1();
    int dn;
    logic [3:0] got;
    dn = 0; got = '0;
    b_valid = 1'b1; b_data = 4'b1001;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) b_data  = 4'b0110;
      if (k == 6) b_valid = 1'b0;
      tests++;
      if (obs_b !== exp_b) begin
        fails++; $display("FAIL div1 k=%0d: got %b want %b", k, obs_b, exp_b);
      end
      if (k < 4) got[k] = b_s_out;
      if (k == 4) begin
        tests++;
        if (b_done !== 1'b1) begin
          fails++; $display("FAIL div1_done_cycle: got %b want 1", b_done);
        end
      end
      if (k == 6) begin
        tests++;
        if ({b_s_valid, b_s_out} !== 2'b10) begin
          fails++; $display("FAIL div1_next_hs: got %b want 10", {b_s_valid, b_s_out});
        end
      end
      if (b_done) dn++;
    end
    tests++;
    if (got !== 4'b1001 || dn != 2) begin
      fails++; $display("FAIL div1_word: got %b done=%0d want 1001 done=2", got, dn);
    end
  endtask

  task test_back_to_back();
    logic sq[$];
    int dn, n0;
    logic [7:0] w0, w1;
    dn = 0; w0 = '0; w1 = '0;
    n0 = hs_a.size();
    a_valid = 1'b1; a_data = 8'h01;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 0)  a_data  = 8'h80;
      if (k == 34) a_valid = 1'b0;
      tests++;
      if (obs_a !== exp_a) begin
        fails++; $display("FAIL b2b k=%0d: got %b want %b", k, obs_a, exp_a);
      end
      if (a_s_valid) sq.push_back(a_s_out);
      if (a_done) dn++;
    end
    if (sq.size() == 64)
      for (int j = 0; j < 8; j++) begin
        w0[j] = sq[j*4];
        w1[j] = sq[32 + j*4];
      end
    tests++;
    if (w0 !== 8'h01 || w1 !== 8'h80) begin
      fails++; $display("FAIL b2b_stream: got %h,%h want 01,80", w0, w1);
    end
    tests++;
    if (dn != 2) begin
      fails++; $display("FAIL b2b_done_count: got %0d want 2", dn);
    end
    tests++;
    if (hs_a.size() != n0 + 2 || hs_a[hs_a.size()-1] - hs_a[hs_a.size()-2] != 34) begin
      fails++; $display("FAIL b2b_hs_gap: got %0d handshakes want 2 spaced 34", hs_a.size() - n0);
    end
  endtask

  task test_random();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_a) begin
        fails++; $display("FAIL random_a k=%0d: got %b want %b", k, obs_a, exp_a);
      end
      tests++;
      if (obs_b !== exp_b) begin
        fails++; $display("FAIL random_b k=%0d: got %b want %b", k, obs_b, exp_b);
      end
      a_reset = ($urandom_range(0, 79) == 0);
      b_reset = ($urandom_range(0, 29) == 0);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_data  = 8'($urandom);
      b_data  = 4'($urandom);
    end
    a_reset = 1'b0; b_reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        fails++; $display("FAIL drain k=%0d: got %b/%b want %b/%b", k, obs_a, obs_b, exp_a, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored();
    test_reset_mid();
    test_div1();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
